// File: rtl/cdb_arbiter_if.sv
// CDB request/broadcast bundle between execution units (master side) and
// the round-robin CDB arbiter (slave side).
interface cdb_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int ROB_WIDTH  = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]                 req_valid;
   logic [N_REQ-1:0]                 req_ready;
   logic [N_REQ-1:0][ROB_WIDTH-1:0]  unit_tag;
   logic [N_REQ-1:0][DATA_WIDTH-1:0] unit_data;
   logic                             flush;
   logic                             cdb_valid;
   logic [ROB_WIDTH-1:0]             cdb_tag;
   logic [DATA_WIDTH-1:0]            cdb_data;
   logic [SW-1:0]                    cdb_src;

   modport master (
      output req_valid, unit_tag, unit_data, flush,
      input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport slave (
      input  req_valid, unit_tag, unit_data, flush,
      output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one requesting unit per cycle and
// broadcasts that unit's registered tag/data on the CDB the next cycle.
module cdb_arbiter #(
   parameter int N_REQ      = 4,
   parameter int ROB_WIDTH  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   cdb_arbiter_if.slave  cdb
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IW = PW + 1;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    bcast_idx_q, bcast_idx_d;
   logic             bcast_valid_q, bcast_valid_d;
   logic [PW-1:0]    gnt_idx;
   logic             found;
   logic [IW-1:0]    cand;
   logic [N_REQ-1:0] grant;

   // Scan ptr, ptr+1, ... modulo N_REQ; the extra bit in cand keeps the
   // wrap correct when N_REQ is not a power of two.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IW'(ptr_q) + IW'(k);
         if (cand >= IW'(N_REQ)) cand = cand - IW'(N_REQ);
         if (!found && cdb.req_valid[cand[PW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[PW-1:0];
         end
      end
      if (cdb.flush || !reset) found = 1'b0;
      if (found) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d         = ptr_q;
      bcast_idx_d   = bcast_idx_q;
      bcast_valid_d = found;
      if (found) begin
         ptr_d       = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         bcast_idx_d = gnt_idx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q         <= '0;
         bcast_valid_q <= 1'b0;
         bcast_idx_q   <= '0;
      end else begin
         ptr_q         <= ptr_d;
         bcast_valid_q <= bcast_valid_d;
         bcast_idx_q   <= bcast_idx_d;
      end
   end

   // A flush in the broadcast cycle discards the already-dispatched result.
   assign cdb.req_ready = grant;
   assign cdb.cdb_valid = bcast_valid_q && !cdb.flush;
   assign cdb.cdb_tag   = cdb.unit_tag[bcast_idx_q];
   assign cdb.cdb_data  = cdb.unit_data[bcast_idx_q];
   assign cdb.cdb_src   = bcast_idx_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Responder end of the per-unit CDB request handshake that execution units, including the load/store unit, raise toward the common data bus.
- Selects one requesting unit per cycle with a round-robin policy and returns ready to that unit only.
- Broadcasts the granted unit's registered result (tag, data) on the CDB in the following cycle.
- One instance drives the GPR CDB and a second drives the FPR CDB.

Parameters:
- N_REQ, 4, number of requesting units (2..8).
- ROB_WIDTH, 4, width of the ROB tag carried on the CDB.
- DATA_WIDTH, 32, width of CDB data.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  unit i has a result ready to broadcast.
- req_ready  out  N_REQ  one-hot grant; unit i dispatches when req_valid[i] && req_ready[i].
- unit_tag  in  N_REQ x ROB_WIDTH  unit i's result tag register; valid in the cycle after its grant.
- unit_data  in  N_REQ x DATA_WIDTH  unit i's result data register; valid in the cycle after its grant.
- flush  in  1  pipeline flush from ROB (mispredict/exception).
- cdb_valid  out  1  CDB carries a valid broadcast this cycle.
- cdb_tag  out  ROB_WIDTH  broadcast tag.
- cdb_data  out  DATA_WIDTH  broadcast data.
- cdb_src  out  clog2(N_REQ)  index of broadcasting unit (debug/verification).

Behaviour:
- State:
  - ptr: priority pointer, clog2(N_REQ) bits.
  - bcast_valid: 1 bit.
  - bcast_idx: clog2(N_REQ) bits.
- Reset (reset==0, asynchronous):
  - ptr=0, bcast_valid=0, bcast_idx=0.
  - While reset is low: req_ready=0, cdb_valid=0, cdb_src=0.
  - Reset released mid-operation: a pending broadcast is lost; units must themselves be reset.
- Grant (combinational):
  - Scan indices ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (mod N_REQ).
  - The first i with req_valid[i]==1 gets req_ready[i]=1; all other req_ready bits are 0.
  - req_ready[i] is never 1 while req_valid[i] is 0.
  - No valid requester: req_ready=0.
  - flush==1: req_ready=0 regardless of req_valid.
- On a rising edge with a grant to index g (and flush==0):
  - ptr <= (g+1) mod N_REQ.
  - bcast_valid <= 1, bcast_idx <= g.
- On a rising edge with no grant: ptr unchanged, bcast_valid <= 0.
- On a rising edge with flush==1: bcast_valid <= 0, ptr unchanged.
- Broadcast stage (combinational from registers):
  - cdb_valid = bcast_valid && !flush.
  - cdb_tag = unit_tag[bcast_idx], cdb_data = unit_data[bcast_idx], cdb_src = bcast_idx.
  - When cdb_valid==0, cdb_tag and cdb_data are don't-care; the bench checks them only when cdb_valid==1.
- Latency: grant in cycle t, broadcast in cycle t+1. Throughput is one broadcast per cycle; grant and broadcast of consecutive results overlap.
- Fairness: a requester that holds req_valid high is granted within N_REQ cycles.
- Requester contract (assertion in bench):
  - req_valid stays high until accepted.
  - unit_tag/unit_data are stable for the whole cycle after the grant.
- Simultaneous events:
  - A unit granted in cycle t may request again in t+1 and compete normally; ptr has moved past it.
  - flush in the broadcast cycle suppresses that broadcast; the unit has already dispatched, so the result is discarded.
- Wrap-around: ptr at N_REQ-1 followed by a grant to N_REQ-1 gives ptr=0.

Test Plan:
- Reset then all req_valid=0 for 5 cycles -> req_ready=0000, cdb_valid=0 every cycle, ptr stays 0.
- req_valid=0010 at t, unit_tag[1]=5, unit_data[1]=0x1234 at t+1 -> req_ready=0010 at t; at t+1 cdb_valid=1, cdb_tag=5, cdb_data=0x1234, cdb_src=1.
- req_valid=1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; cdb_src follows one cycle later; back-to-back cdb_valid=1.
- ptr=3 (after a grant to 2), req_valid=1001 -> grant 3; next cycle ptr=0, grant 0 (wrap-around).
- Grant to unit 2 at t, flush=1 at t+1 with req_valid=0100 -> cdb_valid=0 at t+1, req_ready=0000 at t+1; grant to unit 2 resumes at t+2 once flush=0.
- reset driven low asynchronously mid-cycle while bcast_valid=1 -> cdb_valid and req_ready drop to 0 immediately; after release, first grant is scanned from index 0.
